// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and defaults for the button event detector:
//               FSM state encoding, default hold/repeat periods and the
//               press counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } btn_state_t;

  localparam int unsigned c_long_cycles_dflt   = 50_000_000;
  localparam int unsigned c_repeat_cycles_dflt = 10_000_000;
  localparam int unsigned c_count_w            = 8;

  // Larger of two unsigned values, used to size the shared hold timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_if.sv
`default_nettype none
// ============================================================================
// Module      : button_event_if
// Description : Button level in, event strobes / status / press count out.
//               master = button source and event consumer, slave = detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_event_if;
  import btn_pkg::*;

  logic                 btn_level;
  logic                 press_pulse;
  logic                 release_pulse;
  logic                 long_pulse;
  logic                 repeat_pulse;
  logic                 held;
  logic [c_count_w-1:0] press_count;

  modport master (
    output btn_level,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
  );

  modport slave (
    input  btn_level,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
  );

endinterface
`default_nettype wire

// File: rtl/button_event_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Cycle counter with synchronous clear and enable. at_limit
//               flags count == limit; an enabled cycle at the limit wraps the
//               count back to 0, so the count never passes limit.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clear,
  input  wire logic             enable,
  input  wire logic [WIDTH-1:0] limit,
  output logic                  at_limit
);

  logic [WIDTH-1:0] r_count;

  assign at_limit = (r_count == limit);

  // Count enabled cycles; clear has priority, terminal count wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= at_limit ? '0 : r_count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module      : button_event
// Description : Turns a debounced button level into registered one-cycle
//               press / release / long-press / auto-repeat strobes, a held
//               flag and a wrapping press counter.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = c_long_cycles_dflt,
  parameter int unsigned REPEAT_CYCLES = c_repeat_cycles_dflt
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  button_event_if.slave bus
);

  // One timer serves both thresholds, so size it for the larger one.
  localparam int unsigned c_max_cycles = max_u(LONG_CYCLES, REPEAT_CYCLES);
  localparam int unsigned c_timer_w    = (c_max_cycles <= 2) ? 1 : $clog2(c_max_cycles);
  localparam bit          c_repeat_en  = (REPEAT_CYCLES != 0);
  localparam logic [c_timer_w-1:0] c_long_lim = c_timer_w'(LONG_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_rep_lim  = c_timer_w'(c_repeat_en ? REPEAT_CYCLES - 1 : 0);

  btn_state_t           r_state;
  btn_state_t           w_state_nxt;
  logic                 w_press_nxt;
  logic                 w_release_nxt;
  logic                 w_long_nxt;
  logic                 w_repeat_nxt;
  logic                 w_tmr_clear;
  logic                 w_tmr_enable;
  logic [c_timer_w-1:0] w_tmr_limit;
  logic                 w_tmr_at_limit;

  logic                 r_press;
  logic                 r_release;
  logic                 r_long;
  logic                 r_repeat;
  logic                 r_held;
  logic [c_count_w-1:0] r_count;

  hold_timer #(
    .WIDTH (c_timer_w)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_tmr_clear),
    .enable   (w_tmr_enable),
    .limit    (w_tmr_limit),
    .at_limit (w_tmr_at_limit)
  );

  // Next state, next strobes and timer control; a sampled release always
  // takes precedence over a threshold hit in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_tmr_clear   = 1'b0;
    w_tmr_enable  = 1'b0;
    w_tmr_limit   = c_long_lim;
    case (r_state)
      IDLE: begin
        if (bus.btn_level) begin
          w_state_nxt = HELD;
          w_press_nxt = 1'b1;
          w_tmr_clear = 1'b1;
        end
      end
      HELD: begin
        if (!bus.btn_level) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
          w_tmr_clear   = 1'b1;
        end else begin
          w_tmr_enable = 1'b1;
          w_tmr_limit  = c_long_lim;
          if (w_tmr_at_limit) begin
            w_state_nxt = LONG;
            w_long_nxt  = 1'b1;
          end
        end
      end
      LONG: begin
        if (!bus.btn_level) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
          w_tmr_clear   = 1'b1;
        end else if (c_repeat_en) begin
          w_tmr_enable = 1'b1;
          w_tmr_limit  = c_rep_lim;
          w_repeat_nxt = w_tmr_at_limit;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tmr_clear = 1'b1;
      end
    endcase
  end

  // State register plus registered outputs so every strobe lands one cycle
  // after the edge that sampled its cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      r_held    <= (w_state_nxt != IDLE);
      if (w_press_nxt) begin
        r_count <= r_count + c_count_w'(1);
      end
    end
  end

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.long_pulse    = r_long;
  assign bus.repeat_pulse  = r_repeat;
  assign bus.held          = r_held;
  assign bus.press_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event
// Description : Directed bench for button_event with LONG_CYCLES=8 and
//               REPEAT_CYCLES=4, plus a second instance with repeat disabled.
//               Strobe vectors are {press, release, long, repeat}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_count;
  logic [7:0] exp_count_nr;

  button_event_if bus ();
  button_event_if bus_nr ();

  button_event #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  button_event #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (0)
  ) u_dut_nr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nr)
  );

  logic [3:0] w_strb;
  logic [3:0] w_strb_nr;
  assign w_strb    = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse};
  assign w_strb_nr = {bus_nr.press_pulse, bus_nr.release_pulse, bus_nr.long_pulse, bus_nr.repeat_pulse};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.btn_level = 1'b0;
    bus_nr.btn_level = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (w_strb !== 4'b0000 || bus.held !== 1'b0 || bus.press_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_state got strb=%b held=%b cnt=%0d exp strb=0000 held=0 cnt=0",
               w_strb, bus.held, bus.press_count);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (w_strb !== 4'b0000 || bus.held !== 1'b0 || bus.press_count !== 8'd0) begin
      n_err++;
      $display("FAIL idle_after_reset got strb=%b held=%b cnt=%0d exp strb=0000 held=0 cnt=0",
               w_strb, bus.held, bus.press_count);
    end
    exp_count = 8'd0;
    exp_count_nr = 8'd0;
  endtask

  // High for 3 sampled edges, then low: press at edge 0, release at edge 3.
  task automatic test_short_press();
    logic [3:0] exp;
    for (int i = 0; i < 6; i++) begin
      bus.btn_level = (i < 3);
      tick();
      exp = (i == 0) ? 4'b1000 : (i == 3) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (w_strb !== exp) begin
        n_err++;
        $display("FAIL short_press strobes edge=%0d got=%b exp=%b", i, w_strb, exp);
      end
    end
    exp_count = exp_count + 8'd1;
    n_cmp++;
    if (bus.press_count !== exp_count) begin
      n_err++;
      $display("FAIL short_press count got=%0d exp=%0d", bus.press_count, exp_count);
    end
  endtask

  // High for edges 0..20: long at 8, repeats at 12/16/20, release at 21.
  task automatic test_long_repeat();
    logic [3:0] exp;
    for (int i = 0; i < 24; i++) begin
      bus.btn_level = (i <= 20);
      tick();
      if (i == 0)                           exp = 4'b1000;
      else if (i == 8)                      exp = 4'b0010;
      else if (i == 12 || i == 16 || i == 20) exp = 4'b0001;
      else if (i == 21)                     exp = 4'b0100;
      else                                  exp = 4'b0000;
      n_cmp++;
      if (w_strb !== exp || bus.held !== (i <= 20)) begin
        n_err++;
        $display("FAIL long_repeat edge=%0d got strb=%b held=%b exp strb=%b held=%b",
                 i, w_strb, bus.held, exp, (i <= 20));
      end
    end
    exp_count = exp_count + 8'd1;
    n_cmp++;
    if (bus.press_count !== exp_count) begin
      n_err++;
      $display("FAIL long_repeat count got=%0d exp=%0d", bus.press_count, exp_count);
    end
  endtask

  // Timer reaches 7 after edge 7; release sampled at edge 8 must beat long.
  task automatic test_release_at_threshold();
    logic [3:0] exp;
    for (int i = 0; i < 10; i++) begin
      bus.btn_level = (i < 8);
      tick();
      exp = (i == 0) ? 4'b1000 : (i == 8) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (w_strb !== exp || bus.held !== (i < 8)) begin
        n_err++;
        $display("FAIL release_at_threshold edge=%0d got strb=%b held=%b exp strb=%b held=%b",
                 i, w_strb, bus.held, exp, (i < 8));
      end
    end
    exp_count = exp_count + 8'd1;
  endtask

  // 1,0,1,0,1,0,0 with single-cycle gaps: every transition produces a strobe.
  task automatic test_back_to_back();
    logic [6:0] pat;
    logic [3:0] exp;
    pat = 7'b0010101;
    for (int i = 0; i < 7; i++) begin
      bus.btn_level = pat[i];
      tick();
      if (i == 6)          exp = 4'b0000;
      else if (i % 2 == 0) exp = 4'b1000;
      else                 exp = 4'b0100;
      n_cmp++;
      if (w_strb !== exp) begin
        n_err++;
        $display("FAIL back_to_back edge=%0d got=%b exp=%b", i, w_strb, exp);
      end
    end
    exp_count = exp_count + 8'd3;
    n_cmp++;
    if (bus.press_count !== exp_count) begin
      n_err++;
      $display("FAIL back_to_back count got=%0d exp=%0d", bus.press_count, exp_count);
    end
  endtask

  // 256 short presses: count steps by one each press and wraps past 255.
  task automatic test_count_wrap();
    logic [7:0] start;
    start = exp_count;
    for (int i = 0; i < 256; i++) begin
      bus.btn_level = 1'b1;
      tick();
      bus.btn_level = 1'b0;
      tick();
      exp_count = exp_count + 8'd1;
      n_cmp++;
      if (bus.press_count !== exp_count) begin
        n_err++;
        $display("FAIL count_wrap press=%0d got=%0d exp=%0d", i, bus.press_count, exp_count);
      end
    end
    n_cmp++;
    if (bus.press_count !== start) begin
      n_err++;
      $display("FAIL count_wrap_full got=%0d exp=%0d", bus.press_count, start);
    end
  endtask

  // Reset while long_pulse is up: outputs clear at once, no release follows,
  // and a still-pressed button is a fresh press after deassertion.
  task automatic test_reset_mid_long();
    logic [3:0] exp;
    for (int i = 0; i < 9; i++) begin
      bus.btn_level = 1'b1;
      tick();
      exp = (i == 0) ? 4'b1000 : (i == 8) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (w_strb !== exp) begin
        n_err++;
        $display("FAIL pre_reset_long edge=%0d got=%b exp=%b", i, w_strb, exp);
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (w_strb !== 4'b0000 || bus.held !== 1'b0 || bus.press_count !== 8'd0) begin
      n_err++;
      $display("FAIL async_reset got strb=%b held=%b cnt=%0d exp strb=0000 held=0 cnt=0",
               w_strb, bus.held, bus.press_count);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (w_strb !== 4'b0000 || bus.held !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_release cyc=%0d got strb=%b held=%b exp strb=0000 held=0",
                 i, w_strb, bus.held);
      end
    end
    rst_n = 1'b1;
    exp_count = 8'd0;
    exp_count_nr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      bus.btn_level = (i == 0);
      tick();
      exp = (i == 0) ? 4'b1000 : (i == 1) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (w_strb !== exp) begin
        n_err++;
        $display("FAIL press_after_reset edge=%0d got=%b exp=%b", i, w_strb, exp);
      end
    end
    exp_count = exp_count + 8'd1;
    n_cmp++;
    if (bus.press_count !== exp_count) begin
      n_err++;
      $display("FAIL press_after_reset count got=%0d exp=%0d", bus.press_count, exp_count);
    end
  endtask

  // Repeat disabled: 30 high edges give press, one long, release, no repeat.
  task automatic test_no_repeat();
    logic [3:0] exp;
    int n_long;
    int n_rep;
    n_long = 0;
    n_rep  = 0;
    for (int i = 0; i < 33; i++) begin
      bus_nr.btn_level = (i < 30);
      tick();
      if (bus_nr.long_pulse === 1'b1)   n_long++;
      if (bus_nr.repeat_pulse === 1'b1) n_rep++;
      exp = (i == 0) ? 4'b1000 : (i == 8) ? 4'b0010 : (i == 30) ? 4'b0100 : 4'b0000;
      n_cmp++;
      if (w_strb_nr !== exp) begin
        n_err++;
        $display("FAIL no_repeat edge=%0d got=%b exp=%b", i, w_strb_nr, exp);
      end
    end
    n_cmp++;
    if (n_long != 1 || n_rep != 0) begin
      n_err++;
      $display("FAIL no_repeat totals got long=%0d repeat=%0d exp long=1 repeat=0", n_long, n_rep);
    end
    exp_count_nr = exp_count_nr + 8'd1;
    n_cmp++;
    if (bus_nr.press_count !== exp_count_nr) begin
      n_err++;
      $display("FAIL no_repeat count got=%0d exp=%0d", bus_nr.press_count, exp_count_nr);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_count = 8'd0;
    exp_count_nr = 8'd0;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_at_threshold();
    test_back_to_back();
    test_count_wrap();
    test_reset_mid_long();
    test_no_repeat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
